// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider that owns the HI/LO pair.
// Build option: define MULDIV_SIGNED_EN to add the signed_op port and signed MULT/DIV.
// hi/lo only change on done (or on MTHI/MTLO), so reads during busy see the previous result.
module muldiv_unit #(
    parameter int SIZE  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [SIZE-1:0] operand_a,
    input  logic [SIZE-1:0] operand_b,
`ifdef MULDIV_SIGNED_EN
    input  logic            signed_op,
`endif
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [SIZE-1:0] hi,
    output logic [SIZE-1:0] lo
);
    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
`ifdef MULDIV_SIGNED_EN
        S_FIX,
`endif
        S_DONE
    } state_t;

    state_t           state_q, state_d, fin_st;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0]  acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d;
    logic [SIZE-1:0]  hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d, dbz_q, dbz_d, mt_pend_q, mt_pend_d;
    logic [SIZE:0]    mul_sum, div_trial;
    logic [SIZE-1:0]  div_shift, a_mag, b_mag;
    logic             last;

`ifdef MULDIV_SIGNED_EN
    logic a_neg, b_neg, sgn_q, sgn_d, neg_q, neg_d, rneg_q, rneg_d, isdiv_q, isdiv_d;
    assign a_neg  = signed_op & operand_a[SIZE-1];
    assign b_neg  = signed_op & operand_b[SIZE-1];
    assign a_mag  = a_neg ? -operand_a : operand_a;
    assign b_mag  = b_neg ? -operand_b : operand_b;
    assign fin_st = sgn_q ? S_FIX : S_DONE;
`else
    assign a_mag  = operand_a;
    assign b_mag  = operand_b;
    assign fin_st = S_DONE;
`endif

    // acc_lo holds the multiplier (MUL) or the dividend shifting out / quotient shifting in (DIV)
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    assign div_trial = {acc_hi_q, acc_lo_q[SIZE-1]} - {1'b0, opb_q};
    assign div_shift = {acc_hi_q[SIZE-2:0], acc_lo_q[SIZE-1]};
    assign last      = cnt_q == CNT_W'(SIZE - 1);

    assign busy        = state_q != S_IDLE;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    // Next-state and datapath: accept in IDLE, iterate, optional sign fix, publish in DONE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        done_d    = mt_pend_q;
        mt_pend_d = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn_d     = sgn_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        isdiv_d   = isdiv_q;
`endif
        case (state_q)
            S_IDLE: if (start) begin
                dbz_d    = 1'b0;
                cnt_d    = '0;
                acc_hi_d = '0;
                acc_lo_d = (op == OP_MULT) ? b_mag : a_mag;
                opb_d    = (op == OP_MULT) ? a_mag : b_mag;
`ifdef MULDIV_SIGNED_EN
                sgn_d    = signed_op;
                neg_d    = a_neg ^ b_neg;
                rneg_d   = a_neg;
                isdiv_d  = op == OP_DIV;
`endif
                case (op)
                    OP_MULT: state_d = S_MUL;
                    OP_DIV: begin
                        if (operand_b == '0) begin
                            state_d  = S_DONE;
                            acc_hi_d = operand_a;
                            acc_lo_d = '1;
                            dbz_d    = 1'b1;
                        end else begin
                            state_d = S_DIV;
                        end
                    end
                    OP_MTHI: begin
                        hi_d      = operand_a;
                        mt_pend_d = 1'b1;
                    end
                    default: begin
                        lo_d      = operand_a;
                        mt_pend_d = 1'b1;
                    end
                endcase
            end
            S_MUL: begin
                acc_hi_d = mul_sum[SIZE:1];
                acc_lo_d = {mul_sum[0], acc_lo_q[SIZE-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                state_d  = last ? fin_st : S_MUL;
            end
            S_DIV: begin
                acc_hi_d = div_trial[SIZE] ? div_shift : div_trial[SIZE-1:0];
                acc_lo_d = {acc_lo_q[SIZE-2:0], ~div_trial[SIZE]};
                cnt_d    = cnt_q + CNT_W'(1);
                state_d  = last ? fin_st : S_DIV;
            end
`ifdef MULDIV_SIGNED_EN
            S_FIX: begin
                if (isdiv_q) begin
                    acc_lo_d = neg_q ? -acc_lo_q : acc_lo_q;
                    acc_hi_d = rneg_q ? -acc_hi_q : acc_hi_q;
                end else begin
                    {acc_hi_d, acc_lo_d} = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
                end
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                hi_d    = acc_hi_q;
                lo_d    = acc_lo_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Datapath and architectural registers; reset discards any partial result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            mt_pend_q <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sgn_q     <= 1'b0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            isdiv_q   <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            mt_pend_q <= mt_pend_d;
`ifdef MULDIV_SIGNED_EN
            sgn_q     <= sgn_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            isdiv_q   <= isdiv_d;
`endif
        end
    end
endmodule
